// File: rtl/ex_muldiv_unit_if.sv
// Handshake and result bus between the EX stage and the HI/LO multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       func;
  logic             is_sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             abort;
  logic             busy;
  logic             done;
  logic             start_drop;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, func, is_sign, a, b, flush, abort,
    input  busy, done, start_drop, hi, lo
  );

  modport slave (
    input  start, func, is_sign, a, b, flush, abort,
    output busy, done, start_drop, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit; owns the architectural HI/LO registers.
//
// state      | meaning
// S_IDLE     | no op in flight, MTHI/MTLO write HI/LO directly
// S_MUL      | multiply/MADD/MSUB, result lands after MUL_LAT cycles
// S_DIV_PRE  | take operand magnitudes
// S_DIV_ITER | restoring divide, one quotient bit per cycle for WIDTH cycles
// S_DIV_POST | apply quotient/remainder signs, write HI/LO
module ex_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input logic                clk,
  input logic                rst,
  ex_muldiv_unit_if.slave    md
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_PRE, S_DIV_ITER, S_DIV_POST} state_e;

  localparam logic [2:0] F_MULT = 3'b001;
  localparam logic [2:0] F_DIV  = 3'b010;
  localparam logic [2:0] F_MTHI = 3'b011;
  localparam logic [2:0] F_MTLO = 3'b100;
  localparam logic [2:0] F_MADD = 3'b101;
  localparam logic [2:0] F_MSUB = 3'b110;

  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_INIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sign_q, sign_d;
  logic [2:0]       func_q, func_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             done_q, done_d, drop_q, drop_d;

  logic               accept, busy;
  logic [2*WIDTH-1:0] ax, bx, prod, acc, mul_res;
  logic [WIDTH-1:0]   a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]     rem_sh, diff;

  // Reserved func 111 behaves as NONE; abort never blocks an idle-cycle start.
  always_comb begin
    accept = md.start & ~md.flush & (state_q == S_IDLE) &
             (md.func != 3'b000) & (md.func != 3'b111);
  end

  // State register plus all datapath/result flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      func_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      func_q  <= func_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state: abort pulls any in-flight op back to idle without a write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (md.func == F_DIV) state_d = S_DIV_PRE;
          else if (md.func == F_MULT || md.func == F_MADD || md.func == F_MSUB) state_d = S_MUL;
        end
      end
      S_MUL:      if (md.abort || cnt_q == '0) state_d = S_IDLE;
      S_DIV_PRE:  state_d = md.abort ? S_IDLE : S_DIV_ITER;
      S_DIV_ITER: begin
        if (md.abort) state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_DIV_POST;
      end
      S_DIV_POST: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs: busy is purely state-derived, everything else comes from flops.
  always_comb begin
    busy          = (state_q != S_IDLE);
    md.busy       = busy;
    md.done       = done_q;
    md.start_drop = drop_q;
    md.hi         = hi_q;
    md.lo         = lo_q;
  end

  // Datapath: product/accumulate, restoring divide step, sign fix-up and HI/LO writes.
  always_comb begin
    ax      = sign_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    bx      = sign_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = ax * bx;
    acc     = {hi_q, lo_q};
    case (func_q)
      F_MADD:  mul_res = acc + prod;
      F_MSUB:  mul_res = acc - prod;
      default: mul_res = prod;
    endcase
    // -MIN wraps to MIN, which read unsigned is exactly |MIN|.
    a_mag   = (sign_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag   = (sign_q && b_q[WIDTH-1]) ? -b_q : b_q;
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    q_fix   = (sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
    r_fix   = (sign_q && a_q[WIDTH-1]) ? -rem_q : rem_q;

    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    func_d  = func_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    done_d  = 1'b0;
    drop_d  = md.start & ~md.flush & busy;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d    = md.a;
          b_d    = md.b;
          sign_d = md.is_sign;
          func_d = md.func;
          cnt_d  = MUL_INIT;
          if (md.func == F_MTHI) hi_d = md.a;
          if (md.func == F_MTLO) lo_d = md.a;
        end
      end
      S_MUL: begin
        if (!md.abort) begin
          if (cnt_q == '0) begin
            {hi_d, lo_d} = mul_res;
            done_d       = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_DIV_PRE: begin
        quo_d = a_mag;
        dvs_d = b_mag;
        rem_d = '0;
        cnt_d = DIV_INIT;
      end
      S_DIV_ITER: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      S_DIV_POST: begin
        if (!md.abort) begin
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = r_fix;
            lo_d = q_fix;
          end
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule
